// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - streaming SHA-256 message padder and 512-bit block former
module sha256_padder (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        EMIT      = 2'd1,
        EMIT_PEND = 2'd2,
        EMIT_LAST = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [511:0]   buf_q, buf_d;
    logic [3:0]     wptr_q, wptr_d;
    logic [63:0]    cnt_q, cnt_d;
    logic           first_q, first_d;
    logic           full_q, full_d;

    logic [2:0]     nb;
    logic [6:0]     m;
    logic [63:0]    cnt_new;
    logic [511:0]   word_blk;
    logic [511:0]   last_blk;
    logic           accept;

    always_comb begin
        nb       = 3'd4;
        if (in_last && in_nbytes <= 3'd4) begin
            nb = in_nbytes;
        end
        m        = {1'b0, wptr_q, 2'b00} + {4'd0, nb};
        cnt_new  = cnt_q + {61'd0, nb};

        word_blk = buf_q;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) == wptr_q) begin
                word_blk[511 - 32*i -: 32] = in_data;
            end
        end

        // Bytes at m and beyond are replaced: the pad byte at m, zeros after it.
        last_blk = word_blk;
        for (int b = 0; b < 64; b++) begin
            if (7'(b) == m) begin
                last_blk[511 - 8*b -: 8] = 8'h80;
            end else if (7'(b) > m) begin
                last_blk[511 - 8*b -: 8] = 8'h00;
            end
        end
        if (m <= 7'd55) begin
            last_blk[63:0] = {cnt_new[60:0], 3'b000};
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        wptr_d    = wptr_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        full_d    = full_q;
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        accept    = 1'b0;

        case (state_q)
            FILL: begin
                in_ready = ~reset;
                accept   = in_valid & ~reset;
                if (accept) begin
                    cnt_d = cnt_new;
                    if (in_last) begin
                        buf_d   = last_blk;
                        full_d  = (m == 7'd64);
                        state_d = (m <= 7'd55) ? EMIT_LAST : EMIT_PEND;
                    end else begin
                        buf_d  = word_blk;
                        wptr_d = wptr_q + 4'd1;
                        if (wptr_q == 4'd15) begin
                            state_d = EMIT;
                        end
                    end
                end
            end
            EMIT: begin
                blk_valid = ~reset;
                if (blk_ready) begin
                    wptr_d  = 4'd0;
                    first_d = 1'b0;
                    state_d = FILL;
                end
            end
            EMIT_PEND: begin
                blk_valid = ~reset;
                if (blk_ready) begin
                    // Overflow block: only the length, plus the pad byte if it did not fit.
                    buf_d        = '0;
                    buf_d[63:0]  = {cnt_q[60:0], 3'b000};
                    if (full_q) begin
                        buf_d[511:480] = 32'h8000_0000;
                    end
                    first_d = 1'b0;
                    state_d = EMIT_LAST;
                end
            end
            EMIT_LAST: begin
                blk_valid = ~reset;
                blk_last  = ~reset;
                if (blk_ready) begin
                    cnt_d   = '0;
                    wptr_d  = 4'd0;
                    first_d = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        blk_first = blk_valid & first_q;
        blk_data  = reset ? '0 : buf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            buf_q   <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            full_q  <= full_d;
        end
    end

endmodule
